div_issue_ctrl: RTL and testbench
=================================

Name: div_issue_ctrl

Overview:
- Sequential issue/writeback stage directly upstream and downstream of the 4-bit combinational array divider in the 8-bit RISC datapath.
- Accepts a divide request from decode through a valid/ready handshake and latches the operands.
- Drives the latched operands into the array divider, waits a fixed settle window, then captures quotient and remainder.
- Presents the result to register-file writeback through a valid/ready handshake, with a divide-by-zero bypass and status flags.

Parameters:
- SETTLE_CYCLES, 2: cycles the divider inputs are held stable before capture; legal range 1..15.
- RD_W, 3: destination register index width (8-entry register file).
- DZ_QUOTIENT, 4'hF: quotient reported on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  1  decode offers a divide
- req_ready  output  1  block can accept a request this cycle
- req_a  input  4  dividend
- req_b  input  4  divisor
- req_rd  input  RD_W  destination register
- div_a  output  4  registered dividend to divider A_input
- div_b  output  4  registered divisor to divider B_input
- div_quotient  input  4  divider quotient (combinational from div_a/div_b)
- div_remainder  input  4  divider remainder
- wb_valid  output  1  result available
- wb_ready  input  1  writeback accepts result
- wb_rd  output  RD_W  destination register of result
- wb_quotient  output  4  captured quotient
- wb_remainder  output  4  captured remainder
- flag_dz  output  1  result came from divide-by-zero bypass
- flag_zero  output  1  wb_quotient == 0
- busy  output  1  state != IDLE

Behaviour:
- Reset: asynchronous on rst_n low. State goes to IDLE, counter to 0, and every registered output clears to 0: div_a, div_b, wb_valid, wb_rd, wb_quotient, wb_remainder, flag_dz, flag_zero. Any in-flight operation is discarded; none reaches writeback after release.
- States: IDLE, SETTLE, WB.
- req_ready = (state==IDLE) | (state==WB & wb_ready). This is combinational.
- Accept occurs on an edge where req_valid & req_ready. At that edge the block latches req_a→div_a, req_b→div_b and req_rd into the internal rd register.
- Accept with req_b != 0: go to SETTLE and load counter = SETTLE_CYCLES-1.
- Accept with req_b == 0: bypass the divider and go directly to WB. Set wb_quotient=DZ_QUOTIENT, wb_remainder=req_a, flag_dz=1, flag_zero=(DZ_QUOTIENT==0), wb_valid=1 and wb_rd=req_rd.
- SETTLE: counter decrements each edge. div_a/div_b stay constant.
- On the edge where counter==0 in SETTLE: capture div_quotient→wb_quotient and div_remainder→wb_remainder. Also set flag_dz=0, flag_zero=(div_quotient==0), wb_rd=rd and wb_valid=1, then go to WB.
- Latency, normal path: accept at edge E0; wb_valid is first high in the cycle after edge E0+SETTLE_CYCLES.
- Latency, divide-by-zero path: wb_valid is high in the cycle after E0.
- WB: all wb_* and flag outputs hold stable while wb_valid & !wb_ready (stall, any duration).
- Retire occurs on an edge with wb_valid & wb_ready.
  - If no accept happens on the same edge: clear wb_valid and go to IDLE. wb_quotient, wb_remainder and flags keep their last values.
  - If an accept happens on the same edge: retire and accept together, following the accept rules above. No bubble, no lost result.
- div_a/div_b change only at accept; they hold their last values in IDLE.
- req_valid in SETTLE is ignored, since req_ready=0. Decode must hold the request.
- Divider is combinational only; no capture happens outside the counter==0 edge of SETTLE.
- Arithmetic is unsigned 4-bit. The block does not modify divider results. B=1 is not a special case.

Test Plan:
- Connect a behavioral unsigned divider to div_a/div_b/div_quotient/div_remainder, with SETTLE_CYCLES=2 and wb_ready=1.
  - req 13/4 rd=5 → accept at E0; wb_valid first high after E0+2; q=3, r=1, wb_rd=5, flag_dz=0, flag_zero=0.
  - req 7/0 rd=2 → wb_valid after E0+1; q=4'hF, r=7, flag_dz=1; div_a=7, div_b=0.
  - req 2/5 → q=0, r=2, flag_zero=1.
  - req 15/1 → q=15, r=0, flag_dz=0.
- Hold wb_ready=0 for 5 cycles after 9/2: outputs hold q=4, r=1, wb_valid=1; req_ready=0; a second req 6/3 waits. Raise wb_ready → retire 9/2 and accept 6/3 on the same edge; 6/3 result q=2, r=0 follows SETTLE_CYCLES later.
- Stream 10/3, 8/0, 14/7 with req_valid and wb_ready held high → results (3,1,dz=0), (F,8,dz=1), (2,0,dz=0) appear in order with no gaps beyond settle latency.
- Assert rst_n low one cycle into SETTLE of 11/2 → all outputs 0 immediately; state IDLE, req_ready=1; no wb_valid pulse for 11/2 after release.

Source files
------------

// File: rtl/div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// div_issue_ctrl
//
// Issue/writeback sequencer wrapped around the 4-bit combinational array
// divider of the 8-bit RISC datapath. A divide request is taken from decode
// over a valid/ready handshake. Its operands are registered onto the divider
// inputs and held for SETTLE_CYCLES edges, then quotient and remainder are
// captured. The result is offered to register-file writeback over a second
// valid/ready handshake. A zero divisor skips the divider entirely and
// reports DZ_QUOTIENT with the dividend as remainder.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   req_valid/req_ready         decode handshake (req_ready is combinational)
//   req_a, req_b, req_rd        dividend, divisor, destination register
//   div_a, div_b                registered operands to the array divider
//   div_quotient, div_remainder combinational divider results
//   wb_valid/wb_ready           writeback handshake
//   wb_rd, wb_quotient,
//   wb_remainder                captured result
//   flag_dz                     result came from the divide-by-zero bypass
//   flag_zero                   captured quotient is zero
//   busy                        an operation is in flight or awaiting retire
//
// SETTLE_CYCLES must lie in 1..15 so that the reload value fits the 4-bit
// counter.
// -----------------------------------------------------------------------------
module div_issue_ctrl #(
   parameter int          SETTLE_CYCLES = 2,
   parameter int          RD_W          = 3,
   parameter logic [3:0]  DZ_QUOTIENT   = 4'hF
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [3:0]      req_a,
   input  logic [3:0]      req_b,
   input  logic [RD_W-1:0] req_rd,
   output logic [3:0]      div_a,
   output logic [3:0]      div_b,
   input  logic [3:0]      div_quotient,
   input  logic [3:0]      div_remainder,
   output logic            wb_valid,
   input  logic            wb_ready,
   output logic [RD_W-1:0] wb_rd,
   output logic [3:0]      wb_quotient,
   output logic [3:0]      wb_remainder,
   output logic            flag_dz,
   output logic            flag_zero,
   output logic            busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_WB     = 2'd2
   } state_t;

   // The counter counts down to zero, so it is loaded with one less than the
   // number of edges the divider inputs must stay stable.
   localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
   localparam logic       DZ_ZERO     = (DZ_QUOTIENT == 4'h0);

   state_t          state_r, state_s;
   logic [3:0]      cnt_r, cnt_s;
   logic [RD_W-1:0] rd_r, rd_s;
   logic [3:0]      div_a_r, div_a_s;
   logic [3:0]      div_b_r, div_b_s;
   logic            wb_valid_r, wb_valid_s;
   logic [RD_W-1:0] wb_rd_r, wb_rd_s;
   logic [3:0]      wb_q_r, wb_q_s;
   logic [3:0]      wb_rem_r, wb_rem_s;
   logic            flag_dz_r, flag_dz_s;
   logic            flag_zero_r, flag_zero_s;
   logic            req_ready_s;
   logic            accept_s;

   // Ready whenever idle, or when the held result retires on this same edge.
   always_comb begin
      req_ready_s = (state_r == ST_IDLE) | ((state_r == ST_WB) & wb_ready);
      accept_s    = req_valid & req_ready_s;
   end

   // Next-state and next-output logic. An accept overrides everything else;
   // in WB it also implies that the current result retires on this edge.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      rd_s        = rd_r;
      div_a_s     = div_a_r;
      div_b_s     = div_b_r;
      wb_valid_s  = wb_valid_r;
      wb_rd_s     = wb_rd_r;
      wb_q_s      = wb_q_r;
      wb_rem_s    = wb_rem_r;
      flag_dz_s   = flag_dz_r;
      flag_zero_s = flag_zero_r;

      if (accept_s) begin
         div_a_s = req_a;
         div_b_s = req_b;
         rd_s    = req_rd;
         if (req_b != 4'h0) begin
            state_s    = ST_SETTLE;
            cnt_s      = SETTLE_LOAD;
            wb_valid_s = 1'b0;
         end else begin
            // Divide-by-zero: the result is known now, skip the divider.
            state_s     = ST_WB;
            cnt_s       = 4'h0;
            wb_q_s      = DZ_QUOTIENT;
            wb_rem_s    = req_a;
            flag_dz_s   = 1'b1;
            flag_zero_s = DZ_ZERO;
            wb_valid_s  = 1'b1;
            wb_rd_s     = req_rd;
         end
      end else begin
         case (state_r)
            ST_IDLE: begin
               state_s = ST_IDLE;
            end
            ST_SETTLE: begin
               if (cnt_r == 4'h0) begin
                  wb_q_s      = div_quotient;
                  wb_rem_s    = div_remainder;
                  flag_dz_s   = 1'b0;
                  flag_zero_s = (div_quotient == 4'h0);
                  wb_rd_s     = rd_r;
                  wb_valid_s  = 1'b1;
                  state_s     = ST_WB;
               end else begin
                  cnt_s = cnt_r - 4'd1;
               end
            end
            ST_WB: begin
               // Retire without a follow-on request; result fields keep
               // their values, only the valid drops.
               if (wb_ready) begin
                  wb_valid_s = 1'b0;
                  state_s    = ST_IDLE;
               end else begin
                  state_s = ST_WB;
               end
            end
            default: begin
               state_s    = ST_IDLE;
               cnt_s      = 4'h0;
               wb_valid_s = 1'b0;
            end
         endcase
      end
   end

   // State, counter and all registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         cnt_r       <= 4'h0;
         rd_r        <= '0;
         div_a_r     <= 4'h0;
         div_b_r     <= 4'h0;
         wb_valid_r  <= 1'b0;
         wb_rd_r     <= '0;
         wb_q_r      <= 4'h0;
         wb_rem_r    <= 4'h0;
         flag_dz_r   <= 1'b0;
         flag_zero_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         cnt_r       <= cnt_s;
         rd_r        <= rd_s;
         div_a_r     <= div_a_s;
         div_b_r     <= div_b_s;
         wb_valid_r  <= wb_valid_s;
         wb_rd_r     <= wb_rd_s;
         wb_q_r      <= wb_q_s;
         wb_rem_r    <= wb_rem_s;
         flag_dz_r   <= flag_dz_s;
         flag_zero_r <= flag_zero_s;
      end
   end

   assign req_ready    = req_ready_s;
   assign div_a        = div_a_r;
   assign div_b        = div_b_r;
   assign wb_valid     = wb_valid_r;
   assign wb_rd        = wb_rd_r;
   assign wb_quotient  = wb_q_r;
   assign wb_remainder = wb_rem_r;
   assign flag_dz      = flag_dz_r;
   assign flag_zero    = flag_zero_r;
   assign busy         = (state_r != ST_IDLE);

endmodule

// File: tb/tb_div_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_issue_ctrl
//
// Self-checking bench for div_issue_ctrl. A behavioural unsigned divider is
// attached to the divider port. The reference model works per transaction:
// each accepted request gets its result computed with plain / and %, plus the
// cycle number at which it must become visible (accept edge + latency). From
// that the model derives req_ready, wb_valid, busy and every result field.
// -----------------------------------------------------------------------------
module tb_div_issue_ctrl;

   localparam int SETTLE = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_a, req_b;
   logic [2:0] req_rd;
   logic [3:0] div_a, div_b, div_quotient, div_remainder;
   logic       wb_valid, wb_ready;
   logic [2:0] wb_rd;
   logic [3:0] wb_quotient, wb_remainder;
   logic       flag_dz, flag_zero, busy;

   div_issue_ctrl #(.SETTLE_CYCLES(SETTLE), .RD_W(3), .DZ_QUOTIENT(4'hF)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_rd(req_rd),
      .div_a(div_a), .div_b(div_b),
      .div_quotient(div_quotient), .div_remainder(div_remainder),
      .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd),
      .wb_quotient(wb_quotient), .wb_remainder(wb_remainder),
      .flag_dz(flag_dz), .flag_zero(flag_zero), .busy(busy)
   );

   // behavioural array divider (value on zero divisor is never captured)
   assign div_quotient  = (div_b == 4'h0) ? 4'h0 : div_a / div_b;
   assign div_remainder = (div_b == 4'h0) ? 4'h0 : div_a % div_b;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct packed {
      logic [2:0] rd;
      logic [3:0] q;
      logic [3:0] r;
      logic       dz;
      logic       z;
   } res_t;

   // reference model state
   logic       m_active;
   int         m_ready_cyc;
   res_t       m_job, m_prev;
   logic [3:0] m_div_a, m_div_b;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic res_t calc(input logic [3:0] a, input logic [3:0] b, input logic [2:0] rd);
      res_t res;
      res.rd = rd;
      res.dz = (b == 4'h0);
      res.q  = res.dz ? 4'hF : a / b;
      res.r  = res.dz ? a : a % b;
      res.z  = (res.q == 4'h0);
      return res;
   endfunction

   task automatic model_reset();
      m_active    = 1'b0;
      m_ready_cyc = 0;
      m_job       = '0;
      m_prev      = '0;
      m_div_a     = 4'h0;
      m_div_b     = 4'h0;
   endtask

   // one clock cycle: drive, check against model, advance model
   task automatic step(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] rd, input logic wbr, output logic acc);
      logic vis, exp_rr, ret;
      res_t e;
      @(negedge clk);
      req_valid = v; req_a = a; req_b = b; req_rd = rd; wb_ready = wbr;
      #1;
      vis    = m_active && (cyc >= m_ready_cyc);
      exp_rr = !m_active || (vis && wbr);
      e      = vis ? m_job : m_prev;
      chk("req_ready", 32'(req_ready), 32'(exp_rr));
      chk("wb_valid", 32'(wb_valid), 32'(vis));
      chk("busy", 32'(busy), 32'(m_active));
      chk("div_a", 32'(div_a), 32'(m_div_a));
      chk("div_b", 32'(div_b), 32'(m_div_b));
      chk("wb_rd", 32'(wb_rd), 32'(e.rd));
      chk("wb_quotient", 32'(wb_quotient), 32'(e.q));
      chk("wb_remainder", 32'(wb_remainder), 32'(e.r));
      chk("flag_dz", 32'(flag_dz), 32'(e.dz));
      chk("flag_zero", 32'(flag_zero), 32'(e.z));
      acc = v && exp_rr;
      ret = vis && wbr;
      if (ret) begin
         m_prev   = m_job;
         m_active = 1'b0;
      end
      if (acc) begin
         m_job       = calc(a, b, rd);
         m_active    = 1'b1;
         m_div_a     = a;
         m_div_b     = b;
         m_ready_cyc = cyc + 1 + ((b == 4'h0) ? 0 : SETTLE);
      end
   endtask

   // present a request until accepted (bounded)
   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [2:0] rd, input logic wbr);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(1'b1, a, b, rd, wbr, acc);
      chk("send_accept_timeout", 32'(acc), 32'd1);
   endtask

   task automatic idle(input int n, input logic wbr);
      logic acc;
      for (int i = 0; i < n; i++) step(1'b0, 4'h0, 4'h0, 3'd0, wbr, acc);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = 1'b0;
      #1;
      chk("rst_wb_valid", 32'(wb_valid), 32'd0);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_div_a", 32'(div_a), 32'd0);
      chk("rst_div_b", 32'(div_b), 32'd0);
      chk("rst_wb_rd", 32'(wb_rd), 32'd0);
      chk("rst_wb_quotient", 32'(wb_quotient), 32'd0);
      chk("rst_wb_remainder", 32'(wb_remainder), 32'd0);
      chk("rst_flag_dz", 32'(flag_dz), 32'd0);
      chk("rst_flag_zero", 32'(flag_zero), 32'd0);
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic       acc;
      logic       pend_v;
      logic [3:0] pa, pb;
      logic [2:0] prd;
      rst_n = 1'b0; req_valid = 1'b0; req_a = 4'h0; req_b = 4'h0;
      req_rd = 3'd0; wb_ready = 1'b1;
      model_reset();
      do_reset();

      // basic results, wb_ready held high
      send(4'd13, 4'd4, 3'd5, 1'b1); idle(4, 1'b1);
      send(4'd7,  4'd0, 3'd2, 1'b1); idle(3, 1'b1);
      send(4'd2,  4'd5, 3'd1, 1'b1); idle(4, 1'b1);
      send(4'd15, 4'd1, 3'd7, 1'b1); idle(4, 1'b1);

      // writeback stall with a second request waiting, then retire+accept
      send(4'd9, 4'd2, 3'd3, 1'b0);
      for (int i = 0; i < SETTLE + 5; i++) step(1'b1, 4'd6, 4'd3, 3'd4, 1'b0, acc);
      send(4'd6, 4'd3, 3'd4, 1'b1);
      idle(5, 1'b1);

      // back-to-back stream
      send(4'd10, 4'd3, 3'd1, 1'b1);
      send(4'd8,  4'd0, 3'd2, 1'b1);
      send(4'd14, 4'd7, 3'd3, 1'b1);
      idle(5, 1'b1);

      // reset one cycle into SETTLE; no result may appear afterwards
      send(4'd11, 4'd2, 3'd6, 1'b1);
      idle(1, 1'b1);
      do_reset();
      idle(6, 1'b1);

      // randomized traffic; requests are held until accepted
      pend_v = 1'b0; pa = 4'h0; pb = 4'h0; prd = 3'd0;
      for (int i = 0; i < 1500; i++) begin
         if (!pend_v && $urandom_range(0, 3) != 0) begin
            pend_v = 1'b1;
            pa     = 4'($urandom_range(0, 15));
            pb     = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            prd    = 3'($urandom_range(0, 7));
         end
         step(pend_v, pa, pb, prd, ($urandom_range(0, 3) != 0), acc);
         if (acc) pend_v = 1'b0;
         if ($urandom_range(0, 199) == 0) begin
            do_reset();
            pend_v = 1'b0;
         end
      end
      idle(5, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
